// File: rtl/seg7_pkg.sv
// Shared constants for seven-segment display blocks: blank pattern, hex glyph
// table and an all-ones anode mask helper. All patterns are active-low {g,f,e,d,c,b,a}.
package seg7_pkg;

    localparam logic [6:0] SEG_BLANK = 7'h7F;

    localparam logic [6:0] SEG_HEX [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };

    localparam int MAX_DIG = 8;

    // All anodes dark for an n-digit display (n <= MAX_DIG); callers truncate to width.
    function automatic logic [MAX_DIG-1:0] an_off(input int n);
        an_off = {MAX_DIG{1'b1}} >> (MAX_DIG - n);
    endfunction

endpackage

// File: rtl/seg7_hex_dec.sv
// Combinational hex-to-seven-segment decoder producing the active-low glyph
// for a 4-bit value; shared by display blocks.
module seg7_hex_dec
    import seg7_pkg::*;
(
    input  logic [3:0] value,
    output logic [6:0] seg
);

    assign seg = SEG_HEX[value];

endmodule

// File: rtl/seg7_scan_n.sv
// Multiplexed NDIG-digit common-anode scanner with hex decode, decimal points,
// blanking, leading-zero suppression and 16-level PWM brightness.
module seg7_scan_n
    import seg7_pkg::*;
#(
    parameter int NDIG     = 4,
    parameter int DIV_LOG2 = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [4*NDIG-1:0]   digits,
    input  logic [NDIG-1:0]     dp_in,
    input  logic [NDIG-1:0]     blank,
    input  logic                lz_en,
    input  logic [3:0]          bright,
    output logic [6:0]          seg,
    output logic                dp,
    output logic [NDIG-1:0]     an,
    output logic                slot_start
);

    localparam int SEL_W = (NDIG > 1) ? $clog2(NDIG) : 1;
    localparam logic [NDIG-1:0] AN_OFF = NDIG'(an_off(NDIG));

    logic [DIV_LOG2-1:0] pre_cnt;
    logic [SEL_W-1:0]    sel;
    logic                slot_end;

    logic [NDIG-1:0]     supp;
    logic                zero_run;
    logic [3:0]          cur_val;
    logic                cur_blank;
    logic                cur_dp;
    logic                cur_supp;
    logic                in_window;
    logic                lit;
    logic [6:0]          dec_seg;
    logic [6:0]          seg_next;
    logic                dp_next;
    logic [NDIG-1:0]     an_next;

    assign slot_end = &pre_cnt;

    // A digit is suppressed when it and every digit to its left are zero.
    always_comb begin
        zero_run = 1'b1;
        supp     = '0;
        for (int i = NDIG - 1; i >= 0; i--) begin
            zero_run = zero_run && (digits[4*i +: 4] == 4'd0);
            supp[i]  = lz_en && (i != 0) && zero_run;
        end
    end

    always_comb begin
        cur_val   = 4'd0;
        cur_blank = 1'b0;
        cur_dp    = 1'b0;
        cur_supp  = 1'b0;
        for (int i = 0; i < NDIG; i++) begin
            if (sel == SEL_W'(i)) begin
                cur_val   = digits[4*i +: 4];
                cur_blank = blank[i];
                cur_dp    = dp_in[i];
                cur_supp  = supp[i];
            end
        end
    end

    seg7_hex_dec u_dec (
        .value (cur_val),
        .seg   (dec_seg)
    );

    // PWM window uses the top nibble of the prescaler so duty is independent of DIV.
    always_comb begin
        in_window = (pre_cnt[DIV_LOG2-1 -: 4] <= bright);
        lit       = in_window && !cur_blank && !cur_supp;
        seg_next  = SEG_BLANK;
        dp_next   = 1'b1;
        an_next   = AN_OFF;
        if (lit) begin
            seg_next = dec_seg;
            dp_next  = ~cur_dp;
            an_next  = AN_OFF & ~(NDIG'(1) << sel);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pre_cnt    <= '0;
            sel        <= '0;
            slot_start <= 1'b0;
            seg        <= SEG_BLANK;
            dp         <= 1'b1;
            an         <= AN_OFF;
        end else begin
            pre_cnt    <= pre_cnt + 1'b1;
            if (slot_end) begin
                sel <= (sel == SEL_W'(NDIG - 1)) ? '0 : sel + 1'b1;
            end
            slot_start <= slot_end;
            seg        <= seg_next;
            dp         <= dp_next;
            an         <= an_next;
        end
    end

endmodule

// File: tb/tb_seg7_scan_n.sv
// Scoreboard bench for seg7_scan_n (NDIG=4, DIV=16): a cycle-count reference
// model queues expected pins per edge, a monitor pops and compares on negedge.
module tb_seg7_scan_n;

    localparam int NDIG     = 4;
    localparam int DIV_LOG2 = 4;
    localparam int DIV      = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] digits = 16'h1234;
    logic [3:0]  dp_in = 4'h0;
    logic [3:0]  blank = 4'h0;
    logic        lz_en = 1'b0;
    logic [3:0]  bright = 4'hF;
    logic [6:0]  seg;
    logic        dp;
    logic [3:0]  an;
    logic        slot_start;

    typedef struct packed {
        logic [6:0] seg;
        logic       dp;
        logic [3:0] an;
        logic       ss;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   passed = 0;
    int   edge_idx = 0;

    logic [6:0] hex_ref [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };

    seg7_scan_n #(.NDIG(NDIG), .DIV_LOG2(DIV_LOG2)) dut (
        .clk        (clk),
        .rst        (rst),
        .digits     (digits),
        .dp_in      (dp_in),
        .blank      (blank),
        .lz_en      (lz_en),
        .bright     (bright),
        .seg        (seg),
        .dp         (dp),
        .an         (an),
        .slot_start (slot_start)
    );

    always #5 clk = ~clk;

    // Reference model: edge n after reset shows digit (n/DIV)%NDIG at phase n%DIV.
    always @(posedge clk) begin
        exp_t x;
        int   slot;
        int   phase;
        int   upper;
        bit   vis;
        bit   lit;
        if (rst) begin
            x = '{seg: 7'h7F, dp: 1'b1, an: 4'hF, ss: 1'b0};
            edge_idx = 0;
        end else begin
            slot  = (edge_idx / DIV) % NDIG;
            phase = edge_idx % DIV;
            upper = int'(digits) >> (4 * slot);
            vis   = !blank[slot] && !(lz_en && slot != 0 && upper == 0);
            lit   = vis && (phase <= int'(bright));
            x.seg = lit ? hex_ref[upper % 16] : 7'h7F;
            x.dp  = lit ? !dp_in[slot] : 1'b1;
            x.an  = lit ? ~(4'(1) << slot) : 4'hF;
            x.ss  = (phase == DIV - 1);
            edge_idx++;
        end
        exp_q.push_back(x);
    end

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act == req) passed++;
        else $display("[TB] FAIL %s at %0t: got %0h expected %0h", name, $time, act, req);
    endtask

    task automatic checkOutput(input exp_t x);
        check("seg", int'(seg), int'(x.seg));
        check("dp", int'(dp), int'(x.dp));
        check("an", int'(an), int'(x.an));
        check("slot_start", int'(slot_start), int'(x.ss));
        check("an_onehot", ($countones(~an) <= 1) ? 1 : 0, 1);
    endtask

    always @(negedge clk) begin
        if (exp_q.size() > 0) checkOutput(exp_q.pop_front());
    end

    task automatic applyStimulus(input logic [15:0] d, input logic [3:0] dpi,
                                 input logic [3:0] blk, input logic lz,
                                 input logic [3:0] br, input int ncyc);
        digits = d;
        dp_in  = dpi;
        blank  = blk;
        lz_en  = lz;
        bright = br;
        repeat (ncyc) @(negedge clk);
    endtask

    initial begin
        @(negedge clk);
        rst = 1'b1;
        applyStimulus(16'h1234, 4'h0, 4'h0, 1'b0, 4'hF, 3);
        rst = 1'b0;
        applyStimulus(16'h1234, 4'h0, 4'h0, 1'b0, 4'hF, 64);
        applyStimulus(16'hA7F0, 4'h0, 4'h0, 1'b0, 4'hF, 64);
        applyStimulus(16'h0050, 4'h0, 4'h0, 1'b1, 4'hF, 64);
        applyStimulus(16'h0000, 4'h0, 4'h0, 1'b1, 4'hF, 64);
        applyStimulus(16'h8888, 4'h0, 4'h0, 1'b0, 4'h3, 64);
        applyStimulus(16'h8888, 4'h0, 4'h0, 1'b0, 4'h0, 64);
        applyStimulus(16'h9C3E, 4'b0101, 4'b0010, 1'b0, 4'hF, 64);

        // Align so the next edge samples slot 2, pre_cnt 7, then pulse reset.
        for (int k = 0; k < 2 * NDIG * DIV && (edge_idx % (NDIG * DIV)) != 2 * DIV + 7; k++)
            @(negedge clk);
        check("align_reset", edge_idx % (NDIG * DIV), 2 * DIV + 7);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        applyStimulus(16'h4321, 4'h0, 4'h0, 1'b0, 4'hF, 40);

        for (int n = 0; n < 200; n++) begin
            applyStimulus(16'($urandom), 4'($urandom), ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'h0,
                          1'($urandom), ($urandom_range(0, 3) == 0) ? 4'hF : 4'($urandom),
                          $urandom_range(1, 20));
            if ($urandom_range(0, 2) == 0) digits = digits & 16'h00FF;
            if (n % 50 == 25) begin
                rst = 1'b1;
                @(negedge clk);
                rst = 1'b0;
            end
        end

        repeat (2) @(negedge clk);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
